// File: rtl/key_sched_seq_pkg.sv
// Shared widths, FSM state type, DES PC1/PC2 tables and the C/D rotation helpers
// for the sequential key scheduler.
package key_sched_seq_pkg;

    localparam int unsigned KeyW       = 64;
    localparam int unsigned NumRounds  = 16;
    localparam int unsigned RkW        = 48;
    localparam int unsigned HalfW      = 28;
    // Bit r-1 set for rounds that rotate by a single position.
    localparam logic [15:0] Shift1Mask = 16'b1000_0001_0000_0011;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Tables use DES 1-based numbering with bit 1 as the vector MSB.
    localparam int unsigned Pc1Tab [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned Pc2Tab [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [KeyW-1:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[55-i] = key[KeyW-Pc1Tab[i]];
        end
        return cd;
    endfunction

    function automatic logic [HalfW-1:0] rot28(input logic [HalfW-1:0] x, input logic dec,
                                               input logic [1:0] amt);
        logic [HalfW-1:0] y;
        case ({dec, amt})
            3'b001:  y = {x[26:0], x[27]};
            3'b010:  y = {x[25:0], x[27:26]};
            3'b101:  y = {x[0], x[27:1]};
            3'b110:  y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    // ridx is the 0-based round; decrypt round 0 starts from C16/D16 == C0/D0, so no rotation.
    function automatic logic [55:0] shift_cd(input logic [55:0] cd, input logic [3:0] ridx,
                                             input logic dec);
        logic [1:0] amt;
        amt = Shift1Mask[ridx] ? 2'd1 : 2'd2;
        if (dec && (ridx == 4'd0)) begin
            amt = 2'd0;
        end
        return {rot28(cd[55:28], dec, amt), rot28(cd[27:0], dec, amt)};
    endfunction

endpackage

// File: rtl/key_sched_seq_pc2.sv
// DES permuted choice 2: selects 48 of the 56 C/D bits. Pure wiring.
module key_sched_seq_pc2
    import key_sched_seq_pkg::*;
(
    input  logic [55:0]    i_cd,
    output logic [RkW-1:0] o_rk
);

    for (genvar g = 0; g < RkW; g++) begin : g_bit
        assign o_rk[RkW-1-g] = i_cd[56-Pc2Tab[g]];
    end

endmodule

// File: rtl/key_sched_seq.sv
// Sequential DES key schedule: accepts a key on req, then streams the 16 PC2 subkeys
// one per accepted handshake in encrypt or decrypt order; ack holds until req drops.
module key_sched_seq
    import key_sched_seq_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req,
    output logic            o_ack,
    input  logic [KeyW-1:0] i_k,
    input  logic            i_mode,
    output logic [RkW-1:0]  o_rk,
    output logic            o_rk_valid,
    input  logic            i_rk_ready,
    output logic [3:0]      o_rk_idx
);

    state_e      r_state, w_state_next;
    logic [55:0] r_cd, w_cd_next;
    logic [3:0]  r_idx, w_idx_next;
    logic        r_mode, w_mode_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cd    <= '0;
            r_idx   <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cd    <= w_cd_next;
            r_idx   <= w_idx_next;
            r_mode  <= w_mode_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cd_next    = r_cd;
        w_idx_next   = r_idx;
        w_mode_next  = r_mode;
        case (r_state)
            StIdle: begin
                if (i_req) begin
                    w_cd_next    = shift_cd(pc1(i_k), 4'd0, i_mode);
                    w_idx_next   = 4'd0;
                    w_mode_next  = i_mode;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (i_rk_ready) begin
                    if (r_idx == 4'd15) begin
                        w_state_next = StDone;
                    end else begin
                        w_idx_next = r_idx + 4'd1;
                        w_cd_next  = shift_cd(r_cd, r_idx + 4'd1, r_mode);
                    end
                end
            end
            StDone: begin
                if (!i_req) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    key_sched_seq_pc2 u_pc2 (
        .i_cd (r_cd),
        .o_rk (o_rk)
    );

    assign o_rk_valid = (r_state == StRun);
    assign o_ack      = (r_state == StDone);
    assign o_rk_idx   = r_idx;

endmodule
